// File: rtl/mc_ahb_ctrl_unit.sv
// rtl/mc_ahb_ctrl_unit.sv - multicycle ARM control unit with AHB wait-state stalling and timeout fault
module mc_ahb_ctrl_unit #(
   parameter int ALUCTRL_W    = 3,
   parameter int WAIT_TIMEOUT = 16,
   parameter int SHIFT_EN     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           Op,
   input  logic [5:0]           Funct,
   input  logic [3:0]           Rd,
   input  logic                 HReady,
   output logic [1:0]           FlagW,
   output logic                 PCS,
   output logic                 NextPC,
   output logic                 RegW,
   output logic                 MemW,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic [1:0]           ResultSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 NoWrite,
   output logic                 Shift,
   output logic                 BusReq,
   output logic                 InstrDone,
   output logic                 Fault
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_FAULT
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       wait_expired;
   logic       alu_op, branch;
   logic       regw_raw, memw_raw, irw_raw, nextpc_raw, done_raw;
   logic [2:0] alu_code;
   logic       dp_impl, dp_shift, dp_nowrite;

   // Data-processing decode; unimplemented codes collapse to a harmless no-write op
   always_comb begin
      alu_code   = 3'b000;
      dp_shift   = 1'b0;
      dp_nowrite = 1'b0;
      dp_impl    = 1'b1;
      case (Funct[4:1])
         4'b0100: alu_code = 3'b000;
         4'b0010: alu_code = 3'b001;
         4'b0000: alu_code = 3'b010;
         4'b1100: alu_code = 3'b011;
         4'b0110: alu_code = 3'b101;
         4'b1101: begin
            dp_shift = 1'b1;
            dp_impl  = (SHIFT_EN != 0);
         end
         4'b1000: begin
            alu_code   = 3'b010;
            dp_nowrite = 1'b1;
         end
         4'b1010: begin
            alu_code   = 3'b001;
            dp_nowrite = 1'b1;
         end
         default: dp_impl = 1'b0;
      endcase
      if (!dp_impl) begin
         alu_code = 3'b000;
         dp_shift = 1'b0;
      end
   end

   assign wait_expired = ((wait_cnt + 8'd1) == 8'(WAIT_TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      alu_op       = 1'b0;
      branch       = 1'b0;
      regw_raw     = 1'b0;
      memw_raw     = 1'b0;
      irw_raw      = 1'b0;
      nextpc_raw   = 1'b0;
      done_raw     = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      BusReq       = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            BusReq    = 1'b1;
            if (HReady) begin
               irw_raw    = 1'b1;
               nextpc_raw = 1'b1;
               state_nxt  = S_DECODE;
            end else if (wait_expired) begin
               state_nxt = S_FAULT;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b01:   state_nxt = S_MEMADR;
               2'b00:   state_nxt = !dp_impl ? S_FAULT : (Funct[5] ? S_EXECUTEI : S_EXECUTER);
               2'b10:   state_nxt = S_BRANCH;
               default: state_nxt = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB   = 2'b01;
            state_nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            BusReq = 1'b1;
            if (HReady) state_nxt = S_MEMWB;
            else if (wait_expired) state_nxt = S_FAULT;
            else wait_cnt_nxt = wait_cnt + 8'd1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            BusReq = 1'b1;
            if (HReady) begin
               memw_raw  = 1'b1;
               done_raw  = 1'b1;
               state_nxt = S_FETCH;
            end else if (wait_expired) begin
               state_nxt = S_FAULT;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            regw_raw  = 1'b1;
            done_raw  = 1'b1;
            state_nxt = S_FETCH;
         end
         S_EXECUTER: begin
            alu_op    = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcB   = 2'b01;
            alu_op    = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            alu_op    = 1'b1;
            regw_raw  = dp_impl & ~dp_nowrite;
            done_raw  = 1'b1;
            state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
            done_raw  = 1'b1;
            state_nxt = S_FETCH;
         end
         default: state_nxt = S_FAULT;
      endcase
   end

   // Strobes are forced low while reset is asserted so a mid-stall reset cannot glitch them
   assign RegW      = regw_raw & ~reset;
   assign MemW      = memw_raw & ~reset;
   assign IRWrite   = irw_raw & ~reset;
   assign NextPC    = nextpc_raw & ~reset;
   assign InstrDone = done_raw & ~reset;
   assign PCS       = ((Rd == 4'hF) & RegW) | (branch & ~reset);

   assign ALUControl = alu_op ? ALUCTRL_W'(alu_code) : '0;
   assign Shift      = alu_op & dp_shift;
   assign NoWrite    = alu_op & (dp_nowrite | ~dp_impl);
   assign FlagW[1]   = alu_op & dp_impl & Funct[0];
   assign FlagW[0]   = alu_op & dp_impl & Funct[0] & ~alu_code[1] & ~dp_shift;

   assign ImmSrc = Op;
   assign RegSrc = {Op == 2'b01, Op == 2'b10};
   assign Fault  = (state == S_FAULT);

endmodule
